chan_packet_ctrl: RTL and testbench

Control and framing stage directly downstream of the `chan_packet_regs` software register. It decodes the 32-bit `user_data_out` word in the `user_clk` domain into arm, abort, mode, channel-select and length fields. It then selects one channel from the channelizer sample stream and emits framed packets (SOF/EOF) to the packet transmitter. It also keeps packet and drop counters for readback.

---
 rtl/chan_packet_if.sv | 25 ++
 rtl/chan_packet_ctrl.sv | 143 ++++++++++++++
 tb/tb_chan_packet_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/chan_packet_if.sv
// Sample-stream and packet-stream signals shared by the channel packet
// controller (master) and its surroundings (slave).
interface chan_packet_if #(
    parameter int CH_W = 8
);
    logic [31:0]     ch_data;
    logic            ch_valid;
    logic [CH_W-1:0] ch_num;
    logic            out_ready;
    logic [31:0]     pkt_data;
    logic            pkt_valid;
    logic            pkt_sof;
    logic            pkt_eof;
    logic            pkt_abort;

    modport master (
        input  ch_data, ch_valid, ch_num, out_ready,
        output pkt_data, pkt_valid, pkt_sof, pkt_eof, pkt_abort
    );

    modport slave (
        output ch_data, ch_valid, ch_num, out_ready,
        input  pkt_data, pkt_valid, pkt_sof, pkt_eof, pkt_abort
    );
endinterface

// File: rtl/chan_packet_ctrl.sv
// Decodes the software control word, picks one channel out of the channelizer
// stream and frames it into SOF/EOF packets, with packet and drop counters.
module chan_packet_ctrl #(
    parameter int LEN_W = 10,
    parameter int CH_W  = 8
) (
    input  logic                user_clk,
    input  logic                user_rst,
    input  logic [31:0]         reg_in,
    chan_packet_if.master       bus,
    output logic                busy,
    output logic [15:0]         pkt_count,
    output logic [15:0]         drop_count
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    state_t            done_state_s;
    logic              arm_q_r;
    logic [CH_W-1:0]   sel_r;
    logic [LEN_W-1:0]  len_r;
    logic              cont_r;
    logic [LEN_W-1:0]  word_cnt_r;
    logic [LEN_W-1:0]  cnt_nx_s;
    logic [LEN_W-1:0]  next_cnt_s;
    logic              arm_rise_s;
    logic              abort_s;
    logic              match_s;
    logic              live_s;
    logic              accept_s;
    logic              drop_s;
    logic              first_s;
    logic              last_s;
    logic              unused_bits_s;

    assign unused_bits_s = ^{reg_in[28:24], reg_in[15:LEN_W]};

    // Field decode and per-cycle qualification of the incoming sample.
    always_comb begin
        arm_rise_s = reg_in[31] & ~arm_q_r;
        abort_s    = reg_in[29];
        match_s    = bus.ch_valid & (bus.ch_num == sel_r);
        live_s     = (state_r != ST_IDLE) & ~abort_s;
        accept_s   = live_s & match_s & bus.out_ready;
        drop_s     = live_s & match_s & ~bus.out_ready;
        next_cnt_s = word_cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
        if (state_r == ST_ARMED) begin
            first_s = 1'b1;
            last_s  = (len_r == {LEN_W{1'b0}});
        end else begin
            first_s = 1'b0;
            last_s  = (next_cnt_s == len_r);
        end
    end

    // Next-state and word-index selection; abort overrides everything else.
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = word_cnt_r;
        done_state_s = cont_r ? ST_ARMED : ST_IDLE;
        if (abort_s) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arm_rise_s) begin
                        state_nx_s = ST_ARMED;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (accept_s) begin
                        state_nx_s = last_s ? done_state_s : ST_CAPTURE;
                        cnt_nx_s   = {LEN_W{1'b0}};
                    end else begin
                        state_nx_s = ST_ARMED;
                    end
                end
                ST_CAPTURE: begin
                    if (accept_s) begin
                        state_nx_s = last_s ? done_state_s : ST_CAPTURE;
                        cnt_nx_s   = next_cnt_s;
                    end else begin
                        state_nx_s = ST_CAPTURE;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, latched run parameters, registered packet outputs and counters.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_r       <= ST_IDLE;
            arm_q_r       <= 1'b1;
            sel_r         <= {CH_W{1'b0}};
            len_r         <= {LEN_W{1'b0}};
            cont_r        <= 1'b0;
            word_cnt_r    <= {LEN_W{1'b0}};
            bus.pkt_data  <= 32'd0;
            bus.pkt_valid <= 1'b0;
            bus.pkt_sof   <= 1'b0;
            bus.pkt_eof   <= 1'b0;
            bus.pkt_abort <= 1'b0;
            busy          <= 1'b0;
            pkt_count     <= 16'd0;
            drop_count    <= 16'd0;
        end else begin
            state_r       <= state_nx_s;
            arm_q_r       <= reg_in[31];
            word_cnt_r    <= cnt_nx_s;
            bus.pkt_valid <= accept_s;
            bus.pkt_sof   <= accept_s & first_s;
            bus.pkt_eof   <= accept_s & last_s;
            bus.pkt_abort <= abort_s & (state_r == ST_CAPTURE);
            busy          <= (state_nx_s != ST_IDLE);
            if (!abort_s && (state_r == ST_IDLE) && arm_rise_s) begin
                sel_r  <= CH_W'(reg_in[23:16]);
                len_r  <= reg_in[LEN_W-1:0];
                cont_r <= reg_in[30];
            end
            if (accept_s) begin
                bus.pkt_data <= bus.ch_data;
            end
            if (accept_s && last_s) begin
                pkt_count <= pkt_count + 16'd1;
            end
            // Drop counter sticks at full scale instead of wrapping.
            if (drop_s && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_chan_packet_ctrl.sv
// Directed and randomized checks of chan_packet_ctrl against a packet-level
// reference model (words sent versus words wanted per packet).
module tb_chan_packet_ctrl;
    localparam int LEN_W = 10;
    localparam int CH_W  = 8;

    logic        user_clk = 1'b0;
    logic        user_rst;
    logic [31:0] reg_in;
    logic        busy;
    logic [15:0] pkt_count;
    logic [15:0] drop_count;

    int vectors = 0;
    int miscompares = 0;

    chan_packet_if #(.CH_W(CH_W)) bus ();

    chan_packet_ctrl #(.LEN_W(LEN_W), .CH_W(CH_W)) dut (
        .user_clk   (user_clk),
        .user_rst   (user_rst),
        .reg_in     (reg_in),
        .bus        (bus),
        .busy       (busy),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    always #5 user_clk = ~user_clk;

    // Reference model: a run is "active" from an arm edge until its last packet;
    // a packet is m_total words long and m_sent counts words already sent.
    bit          m_active;
    int          m_sent;
    int          m_total;
    int          m_sel;
    bit          m_cont;
    bit          m_prev_arm;
    int          m_pkts;
    int          m_drops;
    bit          e_valid, e_sof, e_eof, e_abort;
    logic [31:0] e_data;

    task automatic model_step();
        bit match;
        e_valid = 1'b0; e_sof = 1'b0; e_eof = 1'b0; e_abort = 1'b0;
        if (user_rst) begin
            m_active = 1'b0; m_sent = 0; m_pkts = 0; m_drops = 0;
            m_prev_arm = 1'b1; e_data = 32'd0;
            return;
        end
        match = bus.ch_valid && (int'(bus.ch_num) == m_sel);
        if (reg_in[29]) begin
            if (m_active && m_sent > 0) e_abort = 1'b1;
            m_active = 1'b0;
            m_sent = 0;
        end else if (!m_active) begin
            if (reg_in[31] && !m_prev_arm) begin
                m_active = 1'b1;
                m_sent   = 0;
                m_sel    = int'(reg_in[23:16]);
                m_total  = int'(reg_in[9:0]) + 1;
                m_cont   = reg_in[30];
            end
        end else if (match) begin
            if (bus.out_ready) begin
                e_valid = 1'b1;
                e_sof   = (m_sent == 0);
                e_data  = bus.ch_data;
                m_sent++;
                if (m_sent == m_total) begin
                    e_eof    = 1'b1;
                    m_pkts   = (m_pkts + 1) % 65536;
                    m_sent   = 0;
                    m_active = m_cont;
                end
            end else if (m_drops < 65535) begin
                m_drops++;
            end
        end
        m_prev_arm = reg_in[31];
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge user_clk);
        #1;
        chk("flags", 64'({bus.pkt_valid, bus.pkt_sof, bus.pkt_eof, bus.pkt_abort, busy}),
                     64'({e_valid, e_sof, e_eof, e_abort, m_active}));
        chk("pkt_count", 64'(pkt_count), 64'(m_pkts));
        chk("drop_count", 64'(drop_count), 64'(m_drops));
        if (e_valid) chk("pkt_data", 64'(bus.pkt_data), 64'(e_data));
    endtask

    task automatic idle_inputs();
        bus.ch_valid  = 1'b0;
        bus.ch_num    = '0;
        bus.ch_data   = 32'd0;
        bus.out_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        user_rst = 1'b1;
        cycle();
        cycle();
        user_rst = 1'b0;
    endtask

    task automatic arm(input logic [31:0] word);
        idle_inputs();
        reg_in = word & 32'h7FFF_FFFF;
        cycle();
        reg_in = word | 32'h8000_0000;
        cycle();
    endtask

    task automatic feed(input int n, input int ch, input bit cycling, input bit ready);
        for (int i = 0; i < n; i++) begin
            bus.ch_valid  = 1'b1;
            bus.ch_num    = cycling ? CH_W'(i % 8) : CH_W'(ch);
            bus.ch_data   = $urandom;
            bus.out_ready = ready;
            cycle();
        end
        idle_inputs();
    endtask

    initial begin
        // Arm bit held high through reset release must not arm.
        idle_inputs();
        reg_in = 32'h8005_0003;
        do_reset();
        chk("rst_data", 64'(bus.pkt_data), 64'd0);
        chk("rst_outs", 64'({bus.pkt_valid, bus.pkt_sof, bus.pkt_eof, bus.pkt_abort, busy}), 64'd0);
        chk("rst_counts", 64'({pkt_count, drop_count}), 64'd0);
        for (int i = 0; i < 3; i++) cycle();
        chk("no_arm_after_rst", 64'(busy), 64'd0);

        // Single packet: select 5, len 3, channel numbers cycling 0..7.
        arm(32'h0005_0003);
        chk("armed_busy", 64'(busy), 64'd1);
        feed(32, 0, 1'b1, 1'b1);
        chk("single_pkts", 64'(pkt_count), 64'd1);
        chk("single_idle", 64'(busy), 64'd0);

        // Backpressure: first ch-5 sample dropped, next two form the packet.
        do_reset();
        arm(32'h0005_0001);
        feed(1, 5, 1'b0, 1'b0);
        feed(2, 5, 1'b0, 1'b1);
        cycle();
        chk("bp_drops", 64'(drop_count), 64'd1);
        chk("bp_pkts", 64'(pkt_count), 64'd1);

        // len 0 continuous: every sample is its own packet.
        do_reset();
        arm(32'h4005_0000);
        feed(3, 5, 1'b0, 1'b1);
        cycle();
        chk("len0_pkts", 64'(pkt_count), 64'd3);
        chk("len0_busy", 64'(busy), 64'd1);

        // Abort mid-packet, with a competing match in the abort cycle.
        do_reset();
        arm(32'h0005_0007);
        feed(3, 5, 1'b0, 1'b1);
        reg_in = 32'h2005_0007;
        bus.ch_valid = 1'b1; bus.ch_num = CH_W'(5); bus.ch_data = $urandom;
        cycle();
        chk("abort_pulse", 64'({bus.pkt_abort, bus.pkt_valid, busy}), 64'b100);
        idle_inputs();
        cycle();
        chk("abort_once", 64'(bus.pkt_abort), 64'd0);
        chk("abort_pkts", 64'(pkt_count), 64'd0);
        arm(32'h0005_0000);
        feed(1, 5, 1'b0, 1'b1);
        cycle();
        chk("rearm_pkts", 64'(pkt_count), 64'd1);

        // Arm edge and select change during capture are ignored.
        do_reset();
        arm(32'h0005_0003);
        feed(2, 5, 1'b0, 1'b1);
        reg_in = 32'h0006_0003;
        cycle();
        reg_in = 32'h8006_0003;
        cycle();
        feed(24, 0, 1'b1, 1'b1);
        chk("capt_pkts", 64'(pkt_count), 64'd1);
        chk("capt_idle", 64'(busy), 64'd0);

        // Randomized register writes, sample stream, backpressure and resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19, 0) == 0) begin
                reg_in = {1'($urandom), 1'($urandom), ($urandom_range(7, 0) == 0),
                          5'd0, 8'($urandom_range(3, 0)), 6'd0, 10'($urandom_range(5, 0))};
            end
            user_rst      = ($urandom_range(499, 0) == 0);
            bus.ch_valid  = ($urandom_range(9, 0) < 7);
            bus.ch_num    = CH_W'($urandom_range(3, 0));
            bus.ch_data   = $urandom;
            bus.out_ready = ($urandom_range(9, 0) < 8);
            cycle();
        end
        user_rst = 1'b0;

        // Drop counter saturation.
        do_reset();
        arm(32'h0005_03FF);
        feed(65537, 5, 1'b0, 1'b0);
        chk("drop_sat", 64'(drop_count), 64'hFFFF);
        chk("drop_busy", 64'(busy), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
